// File: rtl/axis_vote_histogram.sv
// Per-frame class histogram over voted labels; emits the winning class and its
// vote count as one AXI-Stream beat at the end of each tlast-delimited frame.
module axis_vote_histogram #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [CNT_WIDTH-1:0]  m_axis_tcount,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [CNT_WIDTH-1:0]  invalid_count
);

  localparam int unsigned IDX_W = (NUM_CLASSES > 2) ? $clog2(NUM_CLASSES) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {ACCUM, SCAN, OUTPUT} state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  hist_q [NUM_CLASSES];
  logic [CNT_WIDTH-1:0]  hist_d [NUM_CLASSES];
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      best_q, best_d;
  logic [CNT_WIDTH-1:0]  bestcnt_q, bestcnt_d;
  logic                  tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [CNT_WIDTH-1:0]  tcount_q, tcount_d;
  logic [CNT_WIDTH-1:0]  inv_q, inv_d;
  logic                  s_ready_q, s_ready_d;

  logic                  in_fire;
  logic                  label_ok;
  logic [IDX_W-1:0]      label_idx;
  logic [IDX_W-1:0]      cand_best;
  logic [CNT_WIDTH-1:0]  cand_cnt;

  assign in_fire   = s_axis_tvalid && s_ready_q;
  assign label_ok  = (s_axis_tdata < DATA_WIDTH'(NUM_CLASSES));
  assign label_idx = s_axis_tdata[IDX_W-1:0];

  // Next-state and datapath updates
  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    idx_d     = idx_q;
    best_d    = best_q;
    bestcnt_d = bestcnt_q;
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    tcount_d  = tcount_q;
    inv_d     = inv_q;
    cand_best = best_q;
    cand_cnt  = bestcnt_q;

    case (state_q)
      ACCUM: begin
        if (in_fire) begin
          if (label_ok) begin
            if (hist_q[label_idx] != CNT_MAX) hist_d[label_idx] = hist_q[label_idx] + 1'b1;
          end else if (inv_q != CNT_MAX) begin
            inv_d = inv_q + 1'b1;
          end
          if (s_axis_tlast) begin
            state_d   = SCAN;
            idx_d     = '0;
            best_d    = '0;
            bestcnt_d = '0;
          end
        end
      end
      SCAN: begin
        // Strict compare keeps the lowest index on ties
        if (hist_q[idx_q] > bestcnt_q) begin
          cand_best = idx_q;
          cand_cnt  = hist_q[idx_q];
        end
        best_d    = cand_best;
        bestcnt_d = cand_cnt;
        if (idx_q == IDX_LAST) begin
          tdata_d  = DATA_WIDTH'(cand_best);
          tcount_d = cand_cnt;
          tvalid_d = 1'b1;
          state_d  = OUTPUT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      OUTPUT: begin
        if (m_axis_tready) begin
          for (int i = 0; i < int'(NUM_CLASSES); i++) hist_d[i] = '0;
          tvalid_d = 1'b0;
          state_d  = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase

    s_ready_d = (state_d == ACCUM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      for (int i = 0; i < int'(NUM_CLASSES); i++) hist_q[i] <= '0;
      idx_q     <= '0;
      best_q    <= '0;
      bestcnt_q <= '0;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      tcount_q  <= '0;
      inv_q     <= '0;
      s_ready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      idx_q     <= idx_d;
      best_q    <= best_d;
      bestcnt_q <= bestcnt_d;
      tvalid_q  <= tvalid_d;
      tdata_q   <= tdata_d;
      tcount_q  <= tcount_d;
      inv_q     <= inv_d;
      s_ready_q <= s_ready_d;
    end
  end

  assign s_axis_tready = s_ready_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tcount = tcount_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tvalid_q;
  assign invalid_count = inv_q;

endmodule

// File: tb/tb_axis_vote_histogram.sv
// Scoreboard bench for axis_vote_histogram: directed frames plus random frames
// checked against a frame-level histogram/argmax reference model.
module tb_axis_vote_histogram;

  localparam int unsigned DW   = 32;
  localparam int unsigned NC   = 10;
  localparam int unsigned CW   = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          s_tlast = 1'b0;
  logic [DW-1:0] m_tdata;
  logic [CW-1:0] m_tcount;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic [CW-1:0] inv_cnt;

  axis_vote_histogram #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tcount(m_tcount), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .invalid_count(inv_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cls;
    int unsigned cnt;
    int unsigned inv;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned frame[$];
  int unsigned model_inv = 0;
  int          n_pass = 0;
  int          n_total = 0;
  bit          rand_done = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s: bound expired, got timeout, expected event", name);
  endtask

  // Reference: count labels per class with saturation, pick max count, lowest class on ties
  task automatic model_frame_end();
    int unsigned h[NC];
    exp_t e;
    foreach (h[c]) h[c] = 0;
    foreach (frame[i]) begin
      if (frame[i] < NC) h[frame[i]] = (h[frame[i]] < CMAX) ? h[frame[i]] + 1 : CMAX;
      else model_inv = (model_inv < CMAX) ? model_inv + 1 : CMAX;
    end
    e.cls = 0;
    e.cnt = 0;
    for (int c = 0; c < int'(NC); c++)
      if (h[c] > e.cnt) begin
        e.cls = c;
        e.cnt = h[c];
      end
    e.inv = model_inv;
    exp_q.push_back(e);
    frame.delete();
  endtask

  task automatic send_beat(input int unsigned label, input bit last);
    int b;
    s_tdata  = DW'(label);
    s_tlast  = last;
    s_tvalid = 1'b1;
    b = 0;
    @(negedge clk);
    while (!s_tready && b < 500) begin
      @(negedge clk);
      b++;
    end
    if (!s_tready) begin
      fail("s_ready_wait");
      s_tvalid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    frame.push_back(label);
    if (last) model_frame_end();
  endtask

  task automatic send_frame(input int unsigned labels[$], input int gap_pct);
    foreach (labels[i]) begin
      send_beat(labels[i], i == labels.size() - 1);
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    frame.delete();
    model_inv = 0;
  endtask

  task automatic drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 500) begin
      @(posedge clk);
      b++;
    end
    if (exp_q.size() != 0) fail("drain");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tvalid();
    int b = 0;
    while (!m_tvalid && b < 100) begin
      @(posedge clk);
      #1;
      b++;
    end
    if (!m_tvalid) fail("wait_tvalid");
  endtask

  // Monitor: checks hold stability, tlast, and pops the scoreboard on each output transfer
  logic          hold = 1'b0;
  logic [DW-1:0] h_data;
  logic [CW-1:0] h_cnt;
  always @(negedge clk) begin
    if (rst) begin
      hold <= 1'b0;
    end else begin
      check("m_tlast", m_tlast, m_tvalid);
      if (hold) begin
        check("hold_valid", m_tvalid, 1);
        check("hold_tdata", m_tdata, h_data);
        check("hold_tcount", m_tcount, h_cnt);
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_result: got class %0d count %0d, expected no beat", m_tdata, m_tcount);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result_class", m_tdata, e.cls);
          check("result_count", m_tcount, e.cnt);
          check("invalid_count", inv_cnt, e.inv);
        end
      end
      hold   <= m_tvalid && !m_tready;
      h_data <= m_tdata;
      h_cnt  <= m_tcount;
    end
  end

  initial begin
    int unsigned q[$];
    int n;
    bit seen_ready;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tcount", m_tcount, 0);
    check("rst_invalid", inv_cnt, 0);
    check("rst_s_ready", s_tready, 1);

    // Basic frame with latency and input-stall check
    q = '{3, 3, 5, 3};
    send_frame(q, 0);
    n = 1;
    seen_ready = 1'b0;
    while (!m_tvalid && n < 40) begin
      if (s_tready) seen_ready = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, 11);
    check("s_ready_in_scan", seen_ready, 0);
    drain();

    // Tie resolves low, then histogram clear
    q = '{2, 7, 7, 2};
    send_frame(q, 0);
    q = '{7};
    send_frame(q, 0);
    drain();

    // Out-of-range labels
    q = '{12, 4, 40};
    send_frame(q, 0);
    drain();
    check("invalid_after_3", inv_cnt, 2);
    q = '{15};
    send_frame(q, 0);
    drain();
    check("invalid_after_4", inv_cnt, 3);

    // Backpressure
    m_tready = 1'b0;
    q = '{1, 1};
    send_frame(q, 0);
    wait_tvalid();
    for (int i = 0; i < 20; i++) begin
      check("bp_s_ready", s_tready, 0);
      check("bp_tvalid", m_tvalid, 1);
      @(posedge clk);
      #1;
    end
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_tvalid", m_tvalid, 0);
    check("bp_release_s_ready", s_tready, 1);
    drain();

    // Counter saturation
    q.delete();
    for (int i = 0; i < 20; i++) q.push_back(6);
    send_frame(q, 0);
    drain();

    // Reset mid-frame discards partial counts
    send_beat(5, 1'b0);
    send_beat(5, 1'b0);
    do_reset();
    q = '{8};
    send_frame(q, 0);
    drain();

    // Reset while a result is pending
    m_tready = 1'b0;
    q = '{3, 11};
    send_frame(q, 0);
    wait_tvalid();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_output_tvalid", m_tvalid, 0);
    check("rst_output_invalid", inv_cnt, 0);
    rst = 1'b0;
    exp_q.delete();
    frame.delete();
    model_inv = 0;
    m_tready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("rst_output_s_ready", s_tready, 1);

    // Random frames with random backpressure
    fork
      begin
        for (int f = 0; f < 40; f++) begin
          int len;
          int hi;
          len = $urandom_range(1, 24);
          hi  = ($urandom_range(0, 1) == 0) ? 2 : int'(NC) - 1;
          q.delete();
          for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 15) == 0) q.push_back($urandom_range(NC, 32'hFFFF_FFFF));
            else q.push_back($urandom_range(0, hi));
          end
          send_frame(q, 30);
        end
        drain();
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          m_tready = ($urandom_range(0, 2) != 0);
        end
        m_tready = 1'b1;
      end
    join

    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
